param_multicycle_processor: RTL

- Next-generation multicycle processor core for the DE2 lab system.
- Adds to the six-instruction baseline: parametrised data width and PC width, logic ops, conditional branch and jump, and a Run/stall input.
- Contains the control FSM, the 16-entry register file and the ALU.
- Instruction ROM and data RAM are external, reached through ports.

---
 rtl/param_multicycle_processor_if.sv | 36 +++
 rtl/param_multicycle_processor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/param_multicycle_processor_if.sv
`default_nettype none
// ============================================================================
// Module   : param_multicycle_processor_if
// Brief    : Instruction-ROM and data-RAM bus of the multicycle processor.
// Revision : 1.0 - initial release
// ============================================================================
interface param_multicycle_processor_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 7
) ();
    logic [PC_W-1:0]   Imem_Addr;
    logic [15:0]       Imem_Data;
    logic [7:0]        D_Addr;
    logic              D_Wr;
    logic [DATA_W-1:0] D_WrData;
    logic [DATA_W-1:0] D_RdData;

    modport master (
        output Imem_Addr,
        output D_Addr,
        output D_Wr,
        output D_WrData,
        input  Imem_Data,
        input  D_RdData
    );

    modport slave (
        input  Imem_Addr,
        input  D_Addr,
        input  D_Wr,
        input  D_WrData,
        output Imem_Data,
        output D_RdData
    );
endinterface
`default_nettype wire

// File: rtl/param_multicycle_processor.sv
`default_nettype none
// ============================================================================
// Module   : param_multicycle_processor
// Brief    : Multicycle core: control FSM, 16-entry register file and ALU.
// Revision : 1.0 - initial release
// ============================================================================
module param_multicycle_processor #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 7,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic                Clk,
    input  wire logic                Reset,
    input  wire logic                Run,
    param_multicycle_processor_if.master bus,
    output logic [15:0]              IR_Out,
    output logic [PC_W-1:0]          PC_Out,
    output logic [3:0]               State,
    output logic [3:0]               NextState,
    output logic [DATA_W-1:0]        ALU_A,
    output logic [DATA_W-1:0]        ALU_B,
    output logic [DATA_W-1:0]        ALU_Out,
    output logic                     Halted
);

    localparam logic [3:0] c_ST_INIT   = 4'd0;
    localparam logic [3:0] c_ST_FETCH  = 4'd1;
    localparam logic [3:0] c_ST_DECODE = 4'd2;
    localparam logic [3:0] c_ST_NOOP   = 4'd3;
    localparam logic [3:0] c_ST_LOAD_A = 4'd4;
    localparam logic [3:0] c_ST_LOAD_B = 4'd5;
    localparam logic [3:0] c_ST_STORE  = 4'd6;
    localparam logic [3:0] c_ST_ALU    = 4'd7;
    localparam logic [3:0] c_ST_BRANCH = 4'd8;
    localparam logic [3:0] c_ST_HALT   = 4'd9;

    localparam logic [3:0] c_OP_STORE = 4'b0001;
    localparam logic [3:0] c_OP_LOAD  = 4'b0010;
    localparam logic [3:0] c_OP_ADD   = 4'b0011;
    localparam logic [3:0] c_OP_SUB   = 4'b0100;
    localparam logic [3:0] c_OP_HALT  = 4'b0101;
    localparam logic [3:0] c_OP_AND   = 4'b0110;
    localparam logic [3:0] c_OP_OR    = 4'b0111;
    localparam logic [3:0] c_OP_XOR   = 4'b1000;
    localparam logic [3:0] c_OP_BEQZ  = 4'b1001;
    localparam logic [3:0] c_OP_JMP   = 4'b1010;

    logic [3:0]        r_state;
    logic [3:0]        w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_rf [16];

    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;

    logic              w_d_wr;
    logic              w_ir_load;
    logic              w_pc_load;
    logic              w_rf_we;
    logic [3:0]        w_rf_waddr;
    logic [DATA_W-1:0] w_rf_wdata;

    assign w_op = r_ir[15:12];
    assign w_a  = r_rf[r_ir[11:8]];
    assign w_b  = r_rf[r_ir[7:4]];

    always_comb begin
        w_alu = '0;
        case (w_op)
            c_OP_ADD: w_alu = w_a + w_b;
            c_OP_SUB: w_alu = w_a - w_b;
            c_OP_AND: w_alu = w_a & w_b;
            c_OP_OR:  w_alu = w_a | w_b;
            c_OP_XOR: w_alu = w_a ^ w_b;
            default:  w_alu = '0;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; reset forces INIT so NextState reflects it immediately
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_INIT:   w_next_state = c_ST_FETCH;
            c_ST_FETCH:  w_next_state = Run ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                case (w_op)
                    c_OP_LOAD:  w_next_state = c_ST_LOAD_A;
                    c_OP_STORE: w_next_state = c_ST_STORE;
                    c_OP_ADD,
                    c_OP_SUB,
                    c_OP_AND,
                    c_OP_OR,
                    c_OP_XOR:   w_next_state = c_ST_ALU;
                    c_OP_HALT:  w_next_state = c_ST_HALT;
                    c_OP_BEQZ,
                    c_OP_JMP:   w_next_state = c_ST_BRANCH;
                    default:    w_next_state = c_ST_NOOP;
                endcase
            end
            c_ST_NOOP,
            c_ST_STORE,
            c_ST_ALU,
            c_ST_LOAD_B,
            c_ST_BRANCH: w_next_state = c_ST_FETCH;
            c_ST_LOAD_A: w_next_state = c_ST_LOAD_B;
            c_ST_HALT:   w_next_state = c_ST_HALT;
            default:     w_next_state = c_ST_INIT;
        endcase
        if (Reset) begin
            w_next_state = c_ST_INIT;
        end
    end

    // Per-state control outputs
    always_comb begin
        w_d_wr     = 1'b0;
        w_ir_load  = 1'b0;
        w_pc_load  = 1'b0;
        w_rf_we    = 1'b0;
        w_rf_waddr = r_ir[3:0];
        w_rf_wdata = w_alu;
        case (r_state)
            c_ST_FETCH:  w_ir_load = Run;
            c_ST_STORE:  w_d_wr    = 1'b1;
            c_ST_LOAD_B: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = r_ir[11:8];
                w_rf_wdata = bus.D_RdData;
            end
            c_ST_ALU:    w_rf_we   = 1'b1;
            c_ST_BRANCH: w_pc_load = (w_op == c_OP_JMP) ||
                                     ((w_op == c_OP_BEQZ) && (w_a == '0));
            default:     w_d_wr    = 1'b0;
        endcase
    end

    // PC, IR and register file
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (w_ir_load) begin
                r_ir <= bus.Imem_Data;
                r_pc <= r_pc + PC_W'(1);
            end else if (w_pc_load) begin
                r_pc <= r_ir[PC_W-1:0];
            end
            if (w_rf_we) begin
                r_rf[w_rf_waddr] <= w_rf_wdata;
            end
        end
    end

    assign bus.Imem_Addr = r_pc;
    assign bus.D_Addr    = r_ir[7:0];
    assign bus.D_Wr      = w_d_wr;
    assign bus.D_WrData  = w_a;

    assign IR_Out    = r_ir;
    assign PC_Out    = r_pc;
    assign State     = r_state;
    assign NextState = w_next_state;
    assign ALU_A     = w_a;
    assign ALU_B     = w_b;
    assign ALU_Out   = w_alu;
    assign Halted    = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
